// File: rtl/stream_consumer_if.sv
// stb/ack word-stream channel between a producer (master) and stream_consumer (slave).
interface stream_consumer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] input_a;
  logic             input_a_stb;
  logic             input_a_ack;

  modport master (output input_a, output input_a_stb, input input_a_ack);
  modport slave  (input input_a, input input_a_stb, output input_a_ack);
endinterface

// File: rtl/stream_consumer.sv
// stb/ack stream sink: throttles via ack delay, checks an incrementing sequence.
// Define STREAM_CONSUMER_LFSR_STALL_EN to take per-word stall lengths from a 16-bit LFSR.
module stream_consumer #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] EXPECT_FIRST = 1,
  parameter int unsigned     EXPECT_COUNT = 10,
  parameter int unsigned     STALL_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_consumer_if.slave     in_a,
  output logic [15:0]          count,
  output logic [WIDTH-1:0]     last_value,
  output logic                 error,
  output logic [15:0]          first_bad,
  output logic                 done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             error_q, error_d;
  logic [15:0]      first_bad_q, first_bad_d;
  logic             done_q, done_d;
  logic [15:0]      stall_q, stall_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [15:0]      stall_len;
  logic             xfer;

`ifdef STREAM_CONSUMER_LFSR_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11, shifting toward the MSB
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_len = {12'd0, lfsr_q[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  always_comb stall_len = 16'(STALL_CYCLES);
`endif

  assign xfer = in_a.input_a_stb && ack_q;

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    count_d     = count_q;
    last_d      = last_q;
    error_d     = error_q;
    first_bad_d = first_bad_q;
    done_d      = done_q;
    stall_d     = stall_q;
    expected_d  = expected_q;

    case (state_q)
      S_IDLE: begin
        if (EXPECT_COUNT == 0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (in_a.input_a_stb) begin
          if (stall_len == 16'd0) begin
            state_d = S_ACK;
          end else begin
            stall_d = stall_len;
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        stall_d = stall_q - 16'd1;
        if (stall_q <= 16'd1) state_d = S_ACK;
      end
      S_ACK: begin
        ack_d = 1'b1;
        if (xfer) begin
          ack_d      = 1'b0;
          last_d     = in_a.input_a;
          count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          expected_d = expected_q + WIDTH'(1);
          if (in_a.input_a != expected_q && !error_q) begin
            error_d     = 1'b1;
            first_bad_d = count_q;
          end
          // terminal test uses the pre-saturation count so a full 16-bit count can still finish
          if (32'(count_q) + 32'd1 == EXPECT_COUNT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      count_q     <= '0;
      last_q      <= '0;
      error_q     <= 1'b0;
      first_bad_q <= '0;
      done_q      <= 1'b0;
      stall_q     <= '0;
      expected_q  <= EXPECT_FIRST;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      count_q     <= count_d;
      last_q      <= last_d;
      error_q     <= error_d;
      first_bad_q <= first_bad_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
      expected_q  <= expected_d;
    end
  end

  assign in_a.input_a_ack = ack_q;
  assign count            = count_q;
  assign last_value       = last_q;
  assign error            = error_q;
  assign first_bad        = first_bad_q;
  assign done             = done_q;

endmodule

// File: tb/tb_stream_consumer.sv
// Scoreboard bench for stream_consumer: several parameterisations, one shared expectation queue.
module tb_stream_consumer;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic [31:0] data_r [N];
  logic        stb_r  [N];
  logic        rst_r  [N];
  logic        ack_w  [N];
  logic [15:0] cnt_w  [N];
  logic [15:0] fb_w   [N];
  logic [31:0] lv_w   [N];
  logic        err_w  [N];
  logic        done_w [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    logic [31:0] lv;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  stream_consumer_if #(.WIDTH(32)) if0 ();
  stream_consumer_if #(.WIDTH(32)) if1 ();
  stream_consumer_if #(.WIDTH(32)) if2 ();
  stream_consumer_if #(.WIDTH(32)) if3 ();
  stream_consumer_if #(.WIDTH(32)) if4 ();
  stream_consumer_if #(.WIDTH(32)) if5 ();

  assign if0.input_a = data_r[0]; assign if0.input_a_stb = stb_r[0]; assign ack_w[0] = if0.input_a_ack;
  assign if1.input_a = data_r[1]; assign if1.input_a_stb = stb_r[1]; assign ack_w[1] = if1.input_a_ack;
  assign if2.input_a = data_r[2]; assign if2.input_a_stb = stb_r[2]; assign ack_w[2] = if2.input_a_ack;
  assign if3.input_a = data_r[3]; assign if3.input_a_stb = stb_r[3]; assign ack_w[3] = if3.input_a_ack;
  assign if4.input_a = data_r[4]; assign if4.input_a_stb = stb_r[4]; assign ack_w[4] = if4.input_a_ack;
  assign if5.input_a = data_r[5]; assign if5.input_a_stb = stb_r[5]; assign ack_w[5] = if5.input_a_ack;

  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'd1), .EXPECT_COUNT(10), .STALL_CYCLES(0)) u0 (
    .clk(clk), .rst(rst_r[0]), .in_a(if0.slave), .count(cnt_w[0]), .last_value(lv_w[0]),
    .error(err_w[0]), .first_bad(fb_w[0]), .done(done_w[0]));
  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'd1), .EXPECT_COUNT(10), .STALL_CYCLES(3)) u1 (
    .clk(clk), .rst(rst_r[1]), .in_a(if1.slave), .count(cnt_w[1]), .last_value(lv_w[1]),
    .error(err_w[1]), .first_bad(fb_w[1]), .done(done_w[1]));
  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'd1), .EXPECT_COUNT(4), .STALL_CYCLES(0)) u2 (
    .clk(clk), .rst(rst_r[2]), .in_a(if2.slave), .count(cnt_w[2]), .last_value(lv_w[2]),
    .error(err_w[2]), .first_bad(fb_w[2]), .done(done_w[2]));
  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'hFFFF_FFFF), .EXPECT_COUNT(3), .STALL_CYCLES(0)) u3 (
    .clk(clk), .rst(rst_r[3]), .in_a(if3.slave), .count(cnt_w[3]), .last_value(lv_w[3]),
    .error(err_w[3]), .first_bad(fb_w[3]), .done(done_w[3]));
  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'd1), .EXPECT_COUNT(0), .STALL_CYCLES(0)) u4 (
    .clk(clk), .rst(rst_r[4]), .in_a(if4.slave), .count(cnt_w[4]), .last_value(lv_w[4]),
    .error(err_w[4]), .first_bad(fb_w[4]), .done(done_w[4]));
  stream_consumer #(.WIDTH(32), .EXPECT_FIRST(32'd1), .EXPECT_COUNT(100), .STALL_CYCLES(0)) u5 (
    .clk(clk), .rst(rst_r[5]), .in_a(if5.slave), .count(cnt_w[5]), .last_value(lv_w[5]),
    .error(err_w[5]), .first_bad(fb_w[5]), .done(done_w[5]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // exact latency in the fixed-stall build; with random stalls only the 2..17 envelope is known
  task automatic chk_lat(input string name, input int lat, input int exp);
`ifdef STREAM_CONSUMER_LFSR_STALL_EN
    chk(name, 32'(lat >= 2 && lat <= 17), 32'd1);
`else
    chk(name, 32'(lat), 32'(exp));
`endif
  endtask

  // monitor: every transfer edge pops one expectation and checks the post-edge outputs
  logic [N-1:0] fire;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) fire[i] = stb_r[i] && ack_w[i] && !rst_r[i];
    if (fire != '0) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i]) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected inst%0d: got lv=%0h cnt=%0d, want no transfer", i, lv_w[i], cnt_w[i]);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.inst != i || lv_w[i] !== e.lv || cnt_w[i] !== e.cnt || err_w[i] !== e.err) begin
              bad++;
              $display("FAIL xfer inst%0d: got lv=%0h cnt=%0d err=%0b, want inst%0d lv=%0h cnt=%0d err=%0b",
                       i, lv_w[i], cnt_w[i], err_w[i], e.inst, e.lv, e.cnt, e.err);
            end
          end
        end
      end
    end
  end

  // called at a negedge; returns negedges from strobe raise until ack seen high
  task automatic send(input int i, input logic [31:0] d, input logic [15:0] c, input logic e, output int lat);
    exp_t x;
    x.inst = i; x.lv = d; x.cnt = c; x.err = e;
    sbq.push_back(x);
    data_r[i] = d;
    stb_r[i]  = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (ack_w[i]) break;
      if (lat > 100) begin
        total++; bad++;
        $display("FAIL ack_timeout inst%0d: got no ack in %0d cycles, want ack", i, lat);
        break;
      end
    end
    @(negedge clk);
    stb_r[i] = 1'b0;
  endtask

  initial begin
    int lat, lat_min, lat_max;
    logic seen;
    logic [31:0] seq_c [4];
    logic [31:0] seq_d [3];
    seq_c[0] = 32'd1; seq_c[1] = 32'd2; seq_c[2] = 32'd7; seq_c[3] = 32'd4;
    seq_d[0] = 32'hFFFF_FFFF; seq_d[1] = 32'd0; seq_d[2] = 32'd1;

    for (int i = 0; i < N; i++) begin
      data_r[i] = '0; stb_r[i] = 1'b0; rst_r[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_flags%0d", i), {13'd0, ack_w[i], err_w[i], done_w[i], cnt_w[i]}, 32'd0);
      chk($sformatf("rst_lv%0d", i), lv_w[i], 32'd0);
      chk($sformatf("rst_fb%0d", i), {16'd0, fb_w[i]}, 32'd0);
    end
    for (int i = 0; i < N; i++) rst_r[i] = 1'b0;
    stb_r[4] = 1'b1;
    @(negedge clk);
    chk("e_done_first_cycle", {31'd0, done_w[4]}, 32'd1);
    chk("a_not_done_early", {31'd0, done_w[0]}, 32'd0);

    // A: ten in-order words, no stall
    for (int w = 1; w <= 10; w++) begin
      send(0, 32'(w), 16'(w), 1'b0, lat);
      if (w == 1) chk_lat("a_lat", lat, 2);
    end
    chk("a_done", {31'd0, done_w[0]}, 32'd1);
    chk("a_count", {16'd0, cnt_w[0]}, 32'd10);
    chk("a_last", lv_w[0], 32'd10);
    chk("a_err", {31'd0, err_w[0]}, 32'd0);
    data_r[0] = 32'd11; stb_r[0] = 1'b1; seen = 1'b0;
    repeat (20) begin @(negedge clk); seen = seen | ack_w[0]; end
    stb_r[0] = 1'b0;
    chk("a_ack_after_done", {31'd0, seen}, 32'd0);

    // B: three stall cycles, then reset while stalled
    send(1, 32'd1, 16'd1, 1'b0, lat);
    chk_lat("b_lat", lat, 5);
    chk("b_count", {16'd0, cnt_w[1]}, 32'd1);
    data_r[1] = 32'd1; stb_r[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_r[1] = 1'b1;
    @(negedge clk);
    chk("b_rst_ack", {31'd0, ack_w[1]}, 32'd0);
    chk("b_rst_count", {16'd0, cnt_w[1]}, 32'd0);
    rst_r[1] = 1'b0;
    send(1, 32'd1, 16'd1, 1'b0, lat);
    chk_lat("b_lat_after_rst", lat, 5);
    chk("b_err_after_rst", {31'd0, err_w[1]}, 32'd0);

    // C: sequence mismatch at index 2
    for (int w = 0; w < 4; w++) send(2, seq_c[w], 16'(w + 1), (w >= 2), lat);
    chk("c_first_bad", {16'd0, fb_w[2]}, 32'd2);
    chk("c_done", {31'd0, done_w[2]}, 32'd1);
    chk("c_last", lv_w[2], 32'd4);
    chk("c_count", {16'd0, cnt_w[2]}, 32'd4);

    // D: expected value wraps through zero
    for (int w = 0; w < 3; w++) send(3, seq_d[w], 16'(w + 1), 1'b0, lat);
    chk("d_done", {31'd0, done_w[3]}, 32'd1);
    chk("d_err", {31'd0, err_w[3]}, 32'd0);

    // E: zero-word consumer must never ack
    seen = 1'b0;
    repeat (100) begin @(negedge clk); seen = seen | ack_w[4]; end
    stb_r[4] = 1'b0;
    chk("e_ack_never", {31'd0, seen}, 32'd0);
    chk("e_done", {31'd0, done_w[4]}, 32'd1);

    // F: 100 words, latency spread recorded
    lat_min = 1000; lat_max = 0;
    for (int w = 1; w <= 100; w++) begin
      send(5, 32'(w), 16'(w), 1'b0, lat);
      if (lat < lat_min) lat_min = lat;
      if (lat > lat_max) lat_max = lat;
    end
    chk("f_count", {16'd0, cnt_w[5]}, 32'd100);
    chk("f_err", {31'd0, err_w[5]}, 32'd0);
    chk("f_done", {31'd0, done_w[5]}, 32'd1);
    chk_lat("f_lat_min", lat_min, 2);
    chk_lat("f_lat_max", lat_max, 2);
`ifdef STREAM_CONSUMER_LFSR_STALL_EN
    chk("f_lat_varies", 32'(lat_max > lat_min), 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
